// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative signed/unsigned multiply (shift-add) and divide
//               (restoring), one bit per cycle, with HI/LO result registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int         c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_MULT  = 2'd1;
  localparam logic [1:0] c_DIV   = 2'd2;
  localparam logic [1:0] c_FIX   = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_idle;
  logic               w_fix;
  logic               w_dz;
  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // Operand conditioning: signed ops (op[0]==0) work on magnitudes.
  assign w_a_neg  = ~op[0] & a[WIDTH-1];
  assign w_b_neg  = ~op[0] & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;
  assign w_dz     = w_idle & start & op[1] & (b == '0);
  assign w_accept = w_idle & start & ~w_dz;

  // Multiply step: accumulator high half gathers partial sums, low half holds multiplier.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: remainder in high half, quotient shifts in from the low end.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial    = w_rem_sh - {1'b0, r_opnd};
  assign w_div_next = w_trial[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (w_accept) w_state_nxt = op[1] ? c_DIV : c_MULT;
      c_MULT,
      c_DIV:  if (r_cnt == c_CNT_W'(1)) w_state_nxt = c_FIX;
      c_FIX:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_idle = (r_state == c_IDLE);
    w_fix  = (r_state == c_FIX);
    busy   = ~w_idle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done     <= w_fix | w_dz;
      r_div_zero <= w_dz;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_cnt     <= c_CNT_W'(WIDTH);
            r_is_div  <= op[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_opnd    <= op[1] ? w_b_mag : w_a_mag;
            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
          end
        end
        c_MULT: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt - c_CNT_W'(1);
        end
        c_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt - c_CNT_W'(1);
        end
        default: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
      endcase
    end
  end

  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
  function automatic void model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    longint sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (mop)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, ma} * {32'b0, mb};
      2'b10: begin q = 64'(sa / sb); r = 64'(sa % sb); p = {r[31:0], q[31:0]}; end
      default: p = {ma % mb, ma / mb};
    endcase
    eh = p[63:32];
    el = p[31:0];
  endfunction

  task automatic issue(input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
    @(negedge clk);
    op = iop; a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc = 0; busy_ok = 1'b1;
    if (!busy) busy_ok = 1'b0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (!done && !busy) busy_ok = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] sp [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
    return $urandom;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, div_zero} !== 3'b000 || hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h required all zero", busy, done, div_zero, hi, lo);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]   vop [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10};
    logic [W-1:0] va  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9, 32'h64, 32'h8000_0000};
    logic [W-1:0] vb  [6] = '{32'h5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h2, 32'h7, 32'hFFFF_FFFF};
    logic [W-1:0] vh  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'h2, 32'h0};
    logic [W-1:0] vl  [6] = '{32'hFFFF_FFF1, 32'h1, 32'h0, 32'hFFFF_FFFD, 32'hE, 32'h8000_0000};
    int cyc; bit bok;
    for (int i = 0; i < 6; i++) begin
      issue(vop[i], va[i], vb[i]);
      wait_done(cyc, bok);
      n_checks++;
      if (cyc != LAT || !bok || div_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL directed[%0d] timing: cycles=%0d busy_ok=%0b dz=%b required %0d,1,0", i, cyc, bok, div_zero, LAT);
      end
      n_checks++;
      if (hi !== vh[i] || lo !== vl[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] result: hi=%h lo=%h required hi=%h lo=%h", i, hi, lo, vh[i], vl[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc; bit bok;
    issue(2'b01, 32'h2222_2222, 32'h8000_0001);
    wait_done(cyc, bok);
    n_checks++;
    if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL dz_preload: hi=%h lo=%h required 11111111 22222222", hi, lo);
    end
    issue(2'b11, 32'h7, 32'h0);
    n_checks++;
    if ({done, div_zero, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL dz_pulse: done=%b dz=%b busy=%b required 1 1 0", done, div_zero, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({done, div_zero, busy} !== 3'b000 || hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL dz_after: done=%b dz=%b busy=%b hi=%h lo=%h required 0 0 0 11111111 22222222",
               done, div_zero, busy, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [1:0] rop; logic [W-1:0] ra, rb, eh, el, ph, pl;
    int cyc; bit bok;
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom); ra = pick(); rb = pick();
      ph = hi; pl = lo;
      issue(rop, ra, rb);
      if (rop[1] && rb == '0) begin
        n_checks++;
        if ({done, div_zero, busy} !== 3'b110 || hi !== ph || lo !== pl) begin
          n_fail++;
          $display("FAIL random[%0d] dz: done=%b dz=%b busy=%b hi=%h lo=%h required 1 1 0 %h %h",
                   i, done, div_zero, busy, hi, lo, ph, pl);
        end
        @(posedge clk); #1;
      end else begin
        model(rop, ra, rb, eh, el);
        wait_done(cyc, bok);
        n_checks++;
        if (cyc != LAT || !bok || div_zero !== 1'b0 || hi !== eh || lo !== el) begin
          n_fail++;
          $display("FAIL random[%0d] op=%0d a=%h b=%h: cyc=%0d busy_ok=%0b dz=%b hi=%h lo=%h required %0d 1 0 %h %h",
                   i, rop, ra, rb, cyc, bok, div_zero, hi, lo, LAT, eh, el);
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] eh, el;
    bit early = 1'b0;
    model(2'b10, 32'h0001_2345, 32'hFFFF_FF10, eh, el);
    issue(2'b10, 32'h0001_2345, 32'hFFFF_FF10);
    for (int k = 1; k <= LAT; k++) begin
      if (k == 5) begin op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h3; start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0;
      if (k < LAT && done) early = 1'b1;
    end
    n_checks++;
    if (early || done !== 1'b1 || hi !== eh || lo !== el) begin
      n_fail++;
      $display("FAIL ignore_start: early=%0b done=%b hi=%h lo=%h required 0 1 %h %h", early, done, hi, lo, eh, el);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] eh, el;
    int cyc; bit bok;
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(cyc, bok);
    model(2'b00, 32'hFFFF_0003, 32'h0000_7001, eh, el);
    issue(2'b00, 32'hFFFF_0003, 32'h0000_7001);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b required 1", busy);
    end
    wait_done(cyc, bok);
    n_checks++;
    if (cyc != LAT || !bok || hi !== eh || lo !== el) begin
      n_fail++;
      $display("FAIL b2b_result: cyc=%0d busy_ok=%0b hi=%h lo=%h required %0d 1 %h %h", cyc, bok, hi, lo, LAT, eh, el);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    issue(2'b11, 32'hFFFF_FFF0, 32'h3);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if ({busy, done, div_zero} !== 3'b000 || hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b dz=%b hi=%h lo=%h required all zero", busy, done, div_zero, hi, lo);
    end
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_mid_after: activity=%0b required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
